md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Issue-side controller for the multiply/divide unit, placed in the ID/EX hazard path of the pipelined CPU. It tracks every start-class operation (mult, multu, div, divu, madd) from the cycle it enters EX until the unit deasserts `busy`. While tracking, it stalls any HI/LO-touching instruction held in ID. It also covers the one-cycle gap between start and the unit's registered `busy`, and flags a watchdog error if `busy` never rises or never falls.

## Interface
Parameters:
- MAX_LAT, 16: maximum cycles allowed in BUSY before `md_err` is raised; must be ≥ longest unit latency (10) + 2.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_md_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo or start-class.
- ex_md_start  in  1  EX instruction is start-class; the unit samples start this cycle.
- md_busy  in  1  busy output of the multiply/divide unit.
- stall_id  out  1  freeze PC/IF-ID, bubble into EX (combinational).
- md_pending  out  1  registered; 1 while state ≠ IDLE.
- md_err  out  1  sticky watchdog error, cleared only by reset.
- md_ops  out  CNT_W  count of start-class ops accepted (feature-gated).
- md_stall_cycles  out  CNT_W  count of cycles with stall_id=1 (feature-gated).

## Operation
- States: IDLE, LAUNCH, BUSY.
- IDLE → LAUNCH on an edge where ex_md_start=1.
- LAUNCH → BUSY when md_busy=1. LAUNCH with md_busy=0 for one cycle → set md_err, go to IDLE.
- BUSY: wait counter `wcnt` increments every cycle. On md_busy=0 → IDLE. If wcnt reaches MAX_LAT while md_busy=1 → set md_err, go to IDLE.
- Back-to-back start: ex_md_start=1 while in BUSY cannot occur, because stall_id blocks it. If it is seen anyway, set md_err and remain in BUSY.
- stall_id = id_md_use & (ex_md_start | md_busy | state≠IDLE).
- ex_md_start is never gated by this block. The stall keeps the next HI/LO user in ID, so a bubble is inserted into EX.
- Pipeline flush does not cancel a launched operation. HI/LO are still written when the unit completes.
- Reset: state=IDLE, wcnt=0, md_pending=0, md_err=0, counters=0. stall_id then follows its equation with state=IDLE.
- Reset mid-operation: same values on the next edge. The block does not wait for md_busy to drop.

## Timing
- Edge 0: ex_md_start sampled → LAUNCH; the unit raises md_busy at the same edge.
- Cycle after edge 0: md_busy=1 → BUSY at edge 1.
- Unit with latency D (5 mult/madd, 10 div) holds busy for D+1 cycles. The edge that clears md_busy also writes HI/LO.
- The first cycle with state=IDLE and md_busy=0 releases stall_id. An mfhi/mflo issued that cycle reads the new value.
- Zero-latency path: the stall in the start cycle itself comes from ex_md_start, not from state.
- wcnt is cleared on entry to BUSY and saturates at MAX_LAT.

## Configuration
- MD_PERF_CNT_EN defined:
  - md_ops increments on each edge with ex_md_start=1.
  - md_stall_cycles increments on each edge with stall_id=1.
  - Both wrap modulo 2^CNT_W.
- MD_PERF_CNT_EN undefined: both outputs are constant 0 and no counter registers exist. Control behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles with md_busy=1 and ex_md_start=1 → md_pending=0, md_err=0, counters 0 after release.
- mult then mflo: ex_md_start=1 for 1 cycle, busy held 6 cycles, id_md_use=1 throughout → stall_id=1 for exactly 7 cycles, then 0. md_stall_cycles=7, md_ops=1.
- div then mfhi: busy held 11 cycles → stall_id=1 for 12 cycles. md_pending drops the edge after busy falls.
- Unrelated ID instruction: id_md_use=0 during a mult → stall_id stays 0 throughout, md_pending still high 7 cycles.
- Missing busy: ex_md_start=1, md_busy never rises → md_err=1 two edges later, stays set, state returns to IDLE.
- Stuck busy: busy held 20 cycles with MAX_LAT=16 → md_err=1 when wcnt hits 16. With MD_PERF_CNT_EN undefined, counters read 0 in all of the above.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl -- issue-side controller for the multiply/divide unit.
// Tracks a start-class operation from its EX cycle until the unit drops
// md_busy. While an operation is tracked, it stalls HI/LO users held in ID.
// A watchdog flags a missing or stuck busy.
// Optional performance counters are enabled by defining MD_PERF_CNT_EN.
// When the macro is undefined, md_ops and md_stall_cycles are tied to 0.
module md_issue_ctrl #(
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_md_use,
    input  logic             ex_md_start,
    input  logic             md_busy,
    output logic             stall_id,
    output logic             md_pending,
    output logic             md_err,
    output logic [CNT_W-1:0] md_ops,
    output logic [CNT_W-1:0] md_stall_cycles
);

    localparam int WCNT_W = $clog2(MAX_LAT + 1);
    localparam logic [WCNT_W-1:0] C_MAX_LAT = WCNT_W'(MAX_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_pending;
    logic                r_err;
    logic [WCNT_W-1:0]   w_wcnt_inc;
    logic                w_stall;

    // Wait counter saturates so a stuck unit cannot wrap it back below the limit.
    assign w_wcnt_inc = (r_wcnt == C_MAX_LAT) ? C_MAX_LAT : r_wcnt + 1'b1;

    // Stall covers the start cycle itself (via ex_md_start), the busy window,
    // and the tracked window until the FSM is back in IDLE.
    assign w_stall = id_md_use & (ex_md_start | md_busy | (r_state != ST_IDLE));

    // Tracking FSM with registered pending/error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_md_start) begin
                        r_state   <= ST_LAUNCH;
                        r_pending <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // The unit registers busy at the start edge, so it must be
                    // visible here; otherwise the unit never accepted the op.
                    if (md_busy) begin
                        r_state <= ST_BUSY;
                        r_wcnt  <= '0;
                    end else begin
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_wcnt <= w_wcnt_inc;
                    if (ex_md_start) begin
                        // A second start should have been blocked by stall_id;
                        // keep tracking the operation already in flight.
                        r_err <= 1'b1;
                    end else if (!md_busy) begin
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end else if (w_wcnt_inc == C_MAX_LAT) begin
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign stall_id   = w_stall;
    assign md_pending = r_pending;
    assign md_err     = r_err;

`ifdef MD_PERF_CNT_EN
    logic [CNT_W-1:0] r_ops;
    logic [CNT_W-1:0] r_stall_cnt;

    // Free-running event counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ops       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (ex_md_start) begin
                r_ops <= r_ops + 1'b1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign md_ops          = r_ops;
    assign md_stall_cycles = r_stall_cnt;
`else
    assign md_ops          = '0;
    assign md_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl -- scoreboard bench for md_issue_ctrl.
// The driver pushes the expected stall/pending/error for each cycle it drives.
// A negedge monitor pops each entry and compares it with the DUT outputs.
// Busy is driven like the real unit: it rises the cycle after the start
// cycle and stays high for the configured number of cycles.
module tb_md_issue_ctrl;

    localparam int MAX_LAT = 16;
    localparam int CNT_W   = 32;

    logic             clk;
    logic             reset;
    logic             id_md_use;
    logic             ex_md_start;
    logic             md_busy;
    logic             stall_id;
    logic             md_pending;
    logic             md_err;
    logic [CNT_W-1:0] md_ops;
    logic [CNT_W-1:0] md_stall_cycles;

    typedef struct {
        string tag;
        logic  s;
        logic  p;
        logic  e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_item;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_ops = 0;
    int exp_stc = 0;

    md_issue_ctrl #(
        .MAX_LAT(MAX_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_md_use      (id_md_use),
        .ex_md_start    (ex_md_start),
        .md_busy        (md_busy),
        .stall_id       (stall_id),
        .md_pending     (md_pending),
        .md_err         (md_err),
        .md_ops         (md_ops),
        .md_stall_cycles(md_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop one expected entry per cycle and compare it away from the clock edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_item = sb_q.pop_front();
            $display("[%0t] %s stall=%0b pend=%0b err=%0b", $time, mon_item.tag,
                     stall_id, md_pending, md_err);
            check({mon_item.tag, " stall"}, 32'(stall_id), 32'(mon_item.s));
            check({mon_item.tag, " pend"}, 32'(md_pending), 32'(mon_item.p));
            check({mon_item.tag, " err"}, 32'(md_err), 32'(mon_item.e));
        end
    end

    // Drive one cycle of inputs and, if requested, queue its expected outputs.
    task automatic step(input string tag, input logic r, input logic id, input logic st,
                        input logic bz, input bit chk, input logic es, input logic ep,
                        input logic ee);
        @(posedge clk);
        #1;
        reset       = r;
        id_md_use   = id;
        ex_md_start = st;
        md_busy     = bz;
        if (r) begin
            exp_ops = 0;
            exp_stc = 0;
        end else begin
            if (st) exp_ops++;
            if (es) exp_stc++;
        end
        if (chk) sb_q.push_back('{tag, es, ep, ee});
    endtask

    // Reset for two cycles with start and busy asserted, then one idle check.
    task automatic do_reset(input string tag);
        step({tag, " rst0"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, " rst1"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, " post"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Idle cycle, then compare the counters against the bench's own tallies.
    task automatic check_cnt(input string tag, input logic ee);
        logic [31:0] e_ops;
        logic [31:0] e_stc;
        step({tag, " cnt"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ee);
`ifdef MD_PERF_CNT_EN
        e_ops = 32'(exp_ops);
        e_stc = 32'(exp_stc);
`else
        e_ops = 32'd0;
        e_stc = 32'd0;
`endif
        check({tag, " md_ops"}, 32'(md_ops), e_ops);
        check({tag, " md_stall_cycles"}, 32'(md_stall_cycles), e_stc);
    endtask

    // One start-class op whose busy is high for nbusy cycles after the start cycle.
    // id_on holds a HI/LO user in ID from the next cycle.
    // id_at_start also places it in the start cycle itself.
    task automatic run_op(input string tag, input int nbusy, input logic id_on,
                          input logic id_at_start);
        step({tag, " c0"}, 1'b0, id_at_start, 1'b1, 1'b0, 1'b1, id_at_start, 1'b0, 1'b0);
        for (int k = 1; k <= nbusy; k++) begin
            step($sformatf("%s c%0d", tag, k), 1'b0, id_on, 1'b0, 1'b1, 1'b1, id_on, 1'b1, 1'b0);
        end
        // Busy has dropped but the FSM is still in BUSY for this cycle.
        step($sformatf("%s c%0d", tag, nbusy + 1), 1'b0, id_on, 1'b0, 1'b0, 1'b1, id_on, 1'b1, 1'b0);
        // First IDLE cycle with busy low: stall released.
        step($sformatf("%s c%0d", tag, nbusy + 2), 1'b0, id_on, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_cnt(tag, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        id_md_use   = 1'b0;
        ex_md_start = 1'b0;
        md_busy     = 1'b0;

        do_reset("init");
        check_cnt("init", 1'b0);

        // mult then mflo: 6 busy cycles -> 7 stalled cycles.
        run_op("mult", 6, 1'b1, 1'b0);
        // div then mfhi: 11 busy cycles -> 12 stalled cycles.
        run_op("div", 11, 1'b1, 1'b0);
        // Unrelated instruction in ID: no stall, pending still tracked.
        run_op("unrel", 6, 1'b0, 1'b0);
        // HI/LO user already in ID during the start cycle stalls via ex_md_start.
        run_op("zlat", 6, 1'b1, 1'b1);

        // Reset in the middle of a div: everything returns to idle values.
        step("midrst c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("midrst c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset("midrst");
        check_cnt("midrst", 1'b0);

        // Missing busy: error two edges after the start, state back to IDLE.
        step("nobusy c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("nobusy c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("nobusy c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("nobusy c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_cnt("nobusy", 1'b1);
        do_reset("nobusy");

        // Start seen while BUSY: error, but the in-flight op keeps being tracked.
        step("b2b c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("b2b c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("b2b c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("b2b c3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("b2b c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("b2b c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_cnt("b2b", 1'b1);
        do_reset("b2b");

        // Stuck busy for 20 cycles. BUSY is entered at the edge ending c1 with
        // wcnt=0, so wcnt reaches 16 at the edge ending c17. From c18 the error is
        // set and pending is low. The stall follows busy until busy drops.
        step("stuck c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step($sformatf("stuck c%0d", k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                 logic'(k <= 17), logic'(k >= 18));
        end
        step("stuck c21", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_cnt("stuck", 1'b1);

        // Let the monitor drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
